// File: rtl/sdram_burst_arbiter_if.sv
// Avalon-MM master bus between the burst arbiter and the SDRAM controller.
interface sdram_burst_arbiter_if #(
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned ADDR_W  = 29,
  parameter int unsigned BURST_W = 8
);
  logic [ADDR_W-1:0]   avm_address;
  logic [BURST_W-1:0]  avm_burstcount;
  logic                avm_read;
  logic                avm_write;
  logic [DATA_W-1:0]   avm_writedata;
  logic [DATA_W/8-1:0] avm_byteenable;
  logic                avm_waitrequest;
  logic [DATA_W-1:0]   avm_readdata;
  logic                avm_readdatavalid;

  modport master (
    output avm_address, avm_burstcount, avm_read, avm_write, avm_writedata, avm_byteenable,
    input  avm_waitrequest, avm_readdata, avm_readdatavalid
  );

  modport slave (
    input  avm_address, avm_burstcount, avm_read, avm_write, avm_writedata, avm_byteenable,
    output avm_waitrequest, avm_readdata, avm_readdatavalid
  );
endinterface

// File: rtl/sdram_burst_arbiter.sv
// Round-robin arbiter granting one client burst at a time onto a single
// Avalon-MM master port; reads return on a shared bus qualified per channel.
module sdram_burst_arbiter #(
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned ADDR_W   = 29,
  parameter int unsigned BURST_W  = 8
) (
  input  logic                           clk_clk,
  input  logic                           reset_reset_n,
  input  logic [CHANNELS-1:0]            ch_cmd_valid,
  output logic [CHANNELS-1:0]            ch_cmd_ready,
  input  logic [CHANNELS-1:0]            ch_cmd_write,
  input  logic [CHANNELS*ADDR_W-1:0]     ch_cmd_addr,
  input  logic [CHANNELS*BURST_W-1:0]    ch_cmd_len,
  input  logic [CHANNELS-1:0]            ch_wdata_valid,
  output logic [CHANNELS-1:0]            ch_wdata_ready,
  input  logic [CHANNELS*DATA_W-1:0]     ch_wdata,
  input  logic [CHANNELS*DATA_W/8-1:0]   ch_wbe,
  output logic [DATA_W-1:0]              rd_data,
  output logic [CHANNELS-1:0]            rd_valid,
  output logic [CHANNELS-1:0]            ch_done,
  output logic                           busy,
  output logic                           stray_rd,
  sdram_burst_arbiter_if.master          avm
);

  localparam int unsigned BE_W = DATA_W / 8;
  localparam int unsigned GW   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  typedef enum logic [2:0] {IDLE, RD_CMD, RD_DATA, WR_DATA, DONE} state_t;

  state_t              state;
  logic [GW-1:0]       grant;
  logic [GW-1:0]       last_grant;
  logic [GW-1:0]       win_idx;
  logic                win_found;
  logic [CHANNELS-1:0] win_oh;
  logic [CHANNELS-1:0] grant_oh;
  logic [ADDR_W-1:0]   addr_q;
  logic [BURST_W-1:0]  len_q;
  logic [BURST_W-1:0]  beat_cnt;
  logic [BURST_W-1:0]  beat_nxt;

  logic [ADDR_W-1:0]   addr_arr  [CHANNELS];
  logic [BURST_W-1:0]  len_arr   [CHANNELS];
  logic [DATA_W-1:0]   wdata_arr [CHANNELS];
  logic [BE_W-1:0]     wbe_arr   [CHANNELS];

  for (genvar c = 0; c < CHANNELS; c++) begin : g_unpack
    assign addr_arr[c]  = ch_cmd_addr[c*ADDR_W +: ADDR_W];
    assign len_arr[c]   = ch_cmd_len[c*BURST_W +: BURST_W];
    assign wdata_arr[c] = ch_wdata[c*DATA_W +: DATA_W];
    assign wbe_arr[c]   = ch_wbe[c*BE_W +: BE_W];
  end

  // Rotating priority: channels above last_grant first, then wrap to the rest.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int c = 0; c < int'(CHANNELS); c++) begin
      if (!win_found && ch_cmd_valid[c] && (GW'(c) > last_grant)) begin
        win_found = 1'b1;
        win_idx   = GW'(c);
      end
    end
    for (int c = 0; c < int'(CHANNELS); c++) begin
      if (!win_found && ch_cmd_valid[c] && (GW'(c) <= last_grant)) begin
        win_found = 1'b1;
        win_idx   = GW'(c);
      end
    end
  end

  assign win_oh   = CHANNELS'(1) << win_idx;
  assign grant_oh = CHANNELS'(1) << grant;
  assign beat_nxt = beat_cnt + BURST_W'(1);

  assign busy               = (state != IDLE);
  assign avm.avm_read       = (state == RD_CMD);
  assign avm.avm_address    = addr_q;
  assign avm.avm_burstcount = len_q;

  // Write path passes straight through from the granted channel.
  always_comb begin
    ch_cmd_ready       = '0;
    ch_wdata_ready     = '0;
    avm.avm_write      = 1'b0;
    avm.avm_writedata  = '0;
    avm.avm_byteenable = '0;
    if ((state == IDLE) && win_found && reset_reset_n) begin
      ch_cmd_ready = win_oh;
    end
    if (state == WR_DATA) begin
      avm.avm_write      = ch_wdata_valid[grant];
      avm.avm_writedata  = wdata_arr[grant];
      avm.avm_byteenable = wbe_arr[grant];
      ch_wdata_ready     = avm.avm_waitrequest ? '0 : grant_oh;
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= GW'(CHANNELS - 1);
      addr_q     <= '0;
      len_q      <= '0;
      beat_cnt   <= '0;
      rd_data    <= '0;
      rd_valid   <= '0;
      ch_done    <= '0;
      stray_rd   <= 1'b0;
    end else begin
      rd_valid <= '0;
      ch_done  <= '0;
      stray_rd <= avm.avm_readdatavalid && (state != RD_DATA);
      case (state)
        IDLE: begin
          if (win_found) begin
            grant    <= win_idx;
            addr_q   <= addr_arr[win_idx];
            len_q    <= len_arr[win_idx];
            beat_cnt <= '0;
            if (len_arr[win_idx] == '0)       state <= DONE;
            else if (ch_cmd_write[win_idx])   state <= WR_DATA;
            else                              state <= RD_CMD;
          end
        end
        RD_CMD: begin
          if (!avm.avm_waitrequest) state <= RD_DATA;
        end
        RD_DATA: begin
          if (avm.avm_readdatavalid) begin
            rd_data  <= avm.avm_readdata;
            rd_valid <= grant_oh;
            beat_cnt <= beat_nxt;
            if (beat_nxt == len_q) state <= DONE;
          end
        end
        WR_DATA: begin
          if (avm.avm_write && !avm.avm_waitrequest) begin
            beat_cnt <= beat_nxt;
            if (beat_nxt == len_q) state <= DONE;
          end
        end
        DONE: begin
          ch_done    <= grant_oh;
          last_grant <= grant;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_burst_arbiter.sv
// Randomized bench for sdram_burst_arbiter against a transaction-level model
// of grants, Avalon traffic, read returns and completion pulses.
module tb_sdram_burst_arbiter;

  localparam int unsigned CH  = 2;
  localparam int unsigned DW  = 64;
  localparam int unsigned AW  = 29;
  localparam int unsigned BW  = 8;
  localparam int unsigned BEW = DW / 8;

  logic              clk;
  logic              rst_n;
  logic [CH-1:0]     cmd_valid, cmd_ready, cmd_write, wvalid, wready;
  logic [CH*AW-1:0]  cmd_addr;
  logic [CH*BW-1:0]  cmd_len;
  logic [CH*DW-1:0]  wdata;
  logic [CH*BEW-1:0] wbe;
  logic [DW-1:0]     rd_data;
  logic [CH-1:0]     rd_valid, ch_done;
  logic              busy, stray_rd;

  sdram_burst_arbiter_if #(.DATA_W(DW), .ADDR_W(AW), .BURST_W(BW)) avm_bus ();

  sdram_burst_arbiter #(.CHANNELS(CH), .DATA_W(DW), .ADDR_W(AW), .BURST_W(BW)) dut (
    .clk_clk        (clk),
    .reset_reset_n  (rst_n),
    .ch_cmd_valid   (cmd_valid),
    .ch_cmd_ready   (cmd_ready),
    .ch_cmd_write   (cmd_write),
    .ch_cmd_addr    (cmd_addr),
    .ch_cmd_len     (cmd_len),
    .ch_wdata_valid (wvalid),
    .ch_wdata_ready (wready),
    .ch_wdata       (wdata),
    .ch_wbe         (wbe),
    .rd_data        (rd_data),
    .rd_valid       (rd_valid),
    .ch_done        (ch_done),
    .busy           (busy),
    .stray_rd       (stray_rd),
    .avm            (avm_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // stimulus state
  bit             pend    [CH];
  logic           s_write [CH];
  logic [AW-1:0]  s_addr  [CH];
  logic [BW-1:0]  s_len   [CH];
  int p_wait, p_rdv, p_wv, p_stray, p_newcmd, force_wait, fix_write, fix_len, max_len;
  bit force_stray;

  // reference model: one transaction in flight
  bit            m_busy, m_fin, m_write, m_cmd_sent;
  int            m_ch, m_last, m_len, m_beats;
  logic [AW-1:0] m_addr;
  logic [CH-1:0] e_done, e_rdv;
  bit            e_stray;
  logic [DW-1:0] e_rdata;

  // observations
  int cyc, n_rd_cyc, n_wr_beats, n_avm_any, n_stray, acc_cyc, done_cyc;
  int n_rdv [CH];
  int n_done [CH];
  int grant_log [$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit chance(input int p);
    return int'($urandom_range(1, 100)) <= p;
  endfunction

  function automatic int rr_pick(input logic [CH-1:0] v, input int last);
    for (int k = 1; k <= int'(CH); k++)
      if (v[(last + k) % int'(CH)]) return (last + k) % int'(CH);
    return -1;
  endfunction

  function automatic logic [CH-1:0] oh(input int c);
    logic [CH-1:0] r;
    r = '0;
    r[c] = 1'b1;
    return r;
  endfunction

  function automatic bit rd_cmd_phase();
    return m_busy && !m_fin && !m_write && !m_cmd_sent;
  endfunction

  function automatic bit rd_data_phase();
    return m_busy && !m_fin && !m_write && m_cmd_sent;
  endfunction

  function automatic bit wr_phase();
    return m_busy && !m_fin && m_write;
  endfunction

  function automatic bit pend_any();
    for (int c = 0; c < int'(CH); c++) if (pend[c]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic clear_counts();
    n_rd_cyc = 0; n_wr_beats = 0; n_avm_any = 0; n_stray = 0;
    acc_cyc = -1; done_cyc = -1;
    for (int c = 0; c < int'(CH); c++) begin n_rdv[c] = 0; n_done[c] = 0; end
    grant_log.delete();
  endtask

  task automatic drive_inputs();
    for (int c = 0; c < int'(CH); c++) begin
      if (!pend[c] && p_newcmd > 0 && chance(p_newcmd)) begin
        pend[c]    = 1'b1;
        s_write[c] = (fix_write < 0) ? 1'($urandom_range(0, 1)) : 1'(fix_write);
        s_addr[c]  = AW'($urandom);
        s_len[c]   = (fix_len < 0) ? BW'($urandom_range(0, max_len)) : BW'(fix_len);
      end
      cmd_valid[c]            = pend[c];
      cmd_write[c]            = s_write[c];
      cmd_addr[c*AW +: AW]    = s_addr[c];
      cmd_len[c*BW +: BW]     = s_len[c];
      wvalid[c]               = chance(p_wv);
      wdata[c*DW +: DW]       = {$urandom, $urandom};
      wbe[c*BEW +: BEW]       = BEW'($urandom);
    end
    if (rd_cmd_phase() && force_wait > 0) begin
      avm_bus.avm_waitrequest = 1'b1;
      force_wait--;
    end else begin
      avm_bus.avm_waitrequest = chance(p_wait);
    end
    avm_bus.avm_readdatavalid = rd_data_phase() ? chance(p_rdv) : (force_stray || chance(p_stray));
    force_stray = 1'b0;
    avm_bus.avm_readdata = {$urandom, $urandom};
  endtask

  task automatic check_cycle();
    int w;
    logic [CH-1:0] e_ready, e_wready;
    bit e_rd, e_wr;
    w       = rr_pick(cmd_valid, m_last);
    e_ready = (!m_busy && w >= 0) ? oh(w) : '0;
    e_rd    = rd_cmd_phase();
    e_wr    = wr_phase() && wvalid[m_ch];
    e_wready = (wr_phase() && !avm_bus.avm_waitrequest) ? oh(m_ch) : '0;
    check_eq("busy", busy, m_busy);
    check_eq("cmd_ready", cmd_ready, e_ready);
    check_eq("ch_done", ch_done, e_done);
    check_eq("rd_valid", rd_valid, e_rdv);
    check_eq("stray_rd", stray_rd, e_stray);
    if (e_rdv != '0) check_eq("rd_data", rd_data, e_rdata);
    check_eq("avm_read", avm_bus.avm_read, e_rd);
    if (e_rd) begin
      check_eq("rd_addr", avm_bus.avm_address, m_addr);
      check_eq("rd_burst", avm_bus.avm_burstcount, m_len);
    end
    check_eq("avm_write", avm_bus.avm_write, e_wr);
    check_eq("wdata_ready", wready, e_wready);
    if (e_wr) begin
      check_eq("wr_addr", avm_bus.avm_address, m_addr);
      check_eq("wr_burst", avm_bus.avm_burstcount, m_len);
      check_eq("wr_data", avm_bus.avm_writedata, wdata[m_ch*DW +: DW]);
      check_eq("wr_be", avm_bus.avm_byteenable, wbe[m_ch*BEW +: BEW]);
    end
    if (avm_bus.avm_read) n_rd_cyc++;
    if (avm_bus.avm_write && !avm_bus.avm_waitrequest) n_wr_beats++;
    if (avm_bus.avm_read || avm_bus.avm_write) n_avm_any++;
    if (stray_rd) n_stray++;
    for (int c = 0; c < int'(CH); c++) begin
      if (rd_valid[c]) n_rdv[c]++;
      if (ch_done[c]) begin n_done[c]++; done_cyc = cyc; end
      if (cmd_ready[c] && cmd_valid[c]) begin grant_log.push_back(c); acc_cyc = cyc; end
    end
  endtask

  task automatic model_update();
    int w;
    bit dp, rdv, stall;
    rdv   = avm_bus.avm_readdatavalid;
    stall = avm_bus.avm_waitrequest;
    dp    = rd_data_phase();
    e_done  = '0;
    e_rdv   = '0;
    e_stray = rdv && !dp;
    if (rdv && dp) begin
      e_rdv   = oh(m_ch);
      e_rdata = avm_bus.avm_readdata;
    end
    if (!m_busy) begin
      w = rr_pick(cmd_valid, m_last);
      if (w >= 0) begin
        m_busy = 1'b1; m_ch = w; m_write = s_write[w]; m_addr = s_addr[w];
        m_len = int'(s_len[w]); m_beats = 0; m_cmd_sent = 1'b0;
        m_fin = (m_len == 0);
        pend[w] = 1'b0;
      end
    end else if (m_fin) begin
      m_busy = 1'b0; m_fin = 1'b0;
      e_done = oh(m_ch);
      m_last = m_ch;
    end else if (!m_write) begin
      if (!m_cmd_sent) m_cmd_sent = !stall;
      else if (rdv) begin m_beats++; m_fin = (m_beats == m_len); end
    end else if (wvalid[m_ch] && !stall) begin
      m_beats++;
      m_fin = (m_beats == m_len);
    end
  endtask

  task automatic step();
    drive_inputs();
    #1;
    check_cycle();
    model_update();
    cyc++;
    @(negedge clk);
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic drain(input int max);
    int i;
    i = 0;
    while ((m_busy || pend_any()) && i < max) begin step(); i++; end
    repeat (3) step();
    check_eq("drain_busy", 64'(m_busy), 0);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    cmd_valid = '1; cmd_write = '0; cmd_addr = '1; cmd_len = '1;
    wvalid = '1; wdata = '1; wbe = '1;
    avm_bus.avm_waitrequest = 1'b0;
    avm_bus.avm_readdatavalid = 1'b0;
    avm_bus.avm_readdata = '0;
    #1;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_ready", cmd_ready, 0);
    check_eq("rst_wready", wready, 0);
    check_eq("rst_rd_valid", rd_valid, 0);
    check_eq("rst_done", ch_done, 0);
    check_eq("rst_stray", stray_rd, 0);
    check_eq("rst_rd_data", rd_data, 0);
    check_eq("rst_avm_read", avm_bus.avm_read, 0);
    check_eq("rst_avm_write", avm_bus.avm_write, 0);
    check_eq("rst_avm_addr", avm_bus.avm_address, 0);
    check_eq("rst_avm_burst", avm_bus.avm_burstcount, 0);
    check_eq("rst_avm_wdata", avm_bus.avm_writedata, 0);
    check_eq("rst_avm_be", avm_bus.avm_byteenable, 0);
    cmd_valid = '0; wvalid = '0;
    m_busy = 1'b0; m_fin = 1'b0; m_write = 1'b0; m_cmd_sent = 1'b0;
    m_ch = 0; m_last = int'(CH) - 1; m_len = 0; m_beats = 0; m_addr = '0;
    e_done = '0; e_rdv = '0; e_stray = 1'b0; e_rdata = '0;
    for (int c = 0; c < int'(CH); c++) begin
      pend[c] = 1'b0; s_write[c] = 1'b0; s_addr[c] = '0; s_len[c] = '0;
    end
    force_wait = 0; force_stray = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int i;
    cyc = 0;
    p_wait = 0; p_rdv = 100; p_wv = 100; p_stray = 0; p_newcmd = 0;
    fix_write = -1; fix_len = -1; max_len = 4;
    clear_counts();
    apply_reset();

    // read burst, ch0, addr 0x100, len 4, two stalled command cycles
    clear_counts();
    pend[0] = 1'b1; s_write[0] = 1'b0; s_addr[0] = AW'(32'h100); s_len[0] = BW'(4);
    force_wait = 2;
    drain(60);
    check_eq("r_rdcyc", n_rd_cyc, 3);
    check_eq("r_beats", n_rdv[0], 4);
    check_eq("r_beats_ch1", n_rdv[1], 0);
    check_eq("r_done", n_done[0], 1);

    // round robin with both channels always requesting
    apply_reset();
    clear_counts();
    fix_write = 0; fix_len = 1; p_newcmd = 100;
    run(40);
    p_newcmd = 0;
    drain(60);
    check_eq("rr_count_ge4", 64'(grant_log.size() >= 4), 1);
    for (int k = 0; k < 4 && k < grant_log.size(); k++)
      check_eq("rr_grant", grant_log[k], k % 2);

    // write burst ch1 len 3 with data gaps and stalls
    clear_counts();
    pend[1] = 1'b1; s_write[1] = 1'b1; s_addr[1] = AW'($urandom); s_len[1] = BW'(3);
    p_wv = 50; p_wait = 40;
    drain(200);
    check_eq("w_beats", n_wr_beats, 3);
    check_eq("w_done1", n_done[1], 1);
    check_eq("w_done0", n_done[0], 0);
    p_wv = 100; p_wait = 0;

    // zero-length command
    clear_counts();
    pend[0] = 1'b1; s_write[0] = 1'b0; s_addr[0] = AW'($urandom); s_len[0] = '0;
    drain(20);
    check_eq("z_avm", n_avm_any, 0);
    check_eq("z_done", n_done[0], 1);
    check_eq("z_latency", done_cyc - acc_cyc, 2);

    // stray readdatavalid while idle
    clear_counts();
    force_stray = 1'b1;
    run(4);
    check_eq("s_stray", n_stray, 1);
    check_eq("s_rdv", n_rdv[0] + n_rdv[1], 0);

    // reset in the middle of a read burst
    clear_counts();
    pend[0] = 1'b1; s_write[0] = 1'b0; s_addr[0] = AW'($urandom); s_len[0] = BW'(8);
    i = 0;
    while (m_beats < 2 && i < 30) begin step(); i++; end
    check_eq("a_beats", m_beats, 2);
    check_eq("a_no_done", n_done[0], 0);
    #2;
    apply_reset();
    clear_counts();
    pend[0] = 1'b1; s_write[0] = 1'b0; s_addr[0] = AW'($urandom); s_len[0] = BW'(1);
    pend[1] = 1'b1; s_write[1] = 1'b0; s_addr[1] = AW'($urandom); s_len[1] = BW'(1);
    run(6);
    check_eq("a_log", 64'(grant_log.size() > 0), 1);
    if (grant_log.size() > 0) check_eq("a_first", grant_log[0], 0);
    drain(60);

    // randomized traffic
    fix_write = -1; fix_len = -1; max_len = 6;
    p_newcmd = 20; p_wait = 30; p_rdv = 60; p_wv = 70; p_stray = 2;
    run(2000);
    p_newcmd = 0; p_stray = 0;
    drain(600);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
